// File: rtl/fft_frame_feeder_pkg.sv
// Shared types and sizing helpers for the FFT frame feeder.
package fft_frame_feeder_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        PRIME = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH = 9;
    localparam int FFT_LEN            = 1 << (DEFAULT_ADDR_WIDTH + 1);

    // Frame length for a given counter width parameter.
    function automatic int frame_len(input int addr_width);
        return 1 << (addr_width + 1);
    endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer; registered read port holds its value when not enabled.
module fft_frame_ram #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [1 << ADDR_BITS];

    // NOTE: the storage array is deliberately not reset; only the output register
    // is, so the block still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers one frame of complex samples and streams it to the FFT input on each fft_start.
module fft_frame_feeder
    import fft_frame_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fft_start,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_re,
    input  logic [DATA_WIDTH-1:0]   in_im,
    output logic                    in_ready,
    output logic [2*DATA_WIDTH-1:0] s_axi_data,
    output logic                    s_axi_valid,
    output logic                    s_axi_last,
    input  logic                    s_axi_ready,
    output logic                    busy,
    output logic                    start_drop
);

    localparam int              AW        = ADDR_WIDTH + 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(frame_len(ADDR_WIDTH) - 1);

    state_t          state, state_next;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic            start_pending;
    logic            wr_en, rd_en;
    logic            last_hs;
    logic            launch;

    assign in_ready = (state == FILL) && rst_n;
    assign busy     = (state == PRIME) || (state == SEND);
    assign last_hs  = s_axi_valid && s_axi_ready && s_axi_last;
    assign launch   = (state == FULL) && (start_pending || fft_start);

    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            FILL: begin
                wr_en = in_valid && in_ready;
                if (wr_en && wr_addr == LAST_ADDR) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (launch) begin
                    state_next = PRIME;
                end
            end
            PRIME: begin
                rd_en      = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                // The final sample is already in the output register, so no read on its handshake.
                rd_en = s_axi_valid && s_axi_ready && !s_axi_last;
                if (last_hs) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FILL;
            wr_addr       <= '0;
            rd_addr       <= '0;
            start_pending <= 1'b0;
            start_drop    <= 1'b0;
            s_axi_valid   <= 1'b0;
            s_axi_last    <= 1'b0;
        end else begin
            state <= state_next;

            if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
            end

            // In FULL a start launches directly instead of being queued.
            if (launch) begin
                start_pending <= 1'b0;
            end else if (fft_start && state != FULL) begin
                start_pending <= 1'b1;
            end

            if (fft_start && start_pending) begin
                start_drop <= 1'b1;
            end

            if (state == PRIME) begin
                s_axi_valid <= 1'b1;
            end else if (last_hs) begin
                s_axi_valid <= 1'b0;
            end

            if (rd_en && rd_addr == LAST_ADDR) begin
                s_axi_last <= 1'b1;
            end else if (last_hs) begin
                s_axi_last <= 1'b0;
            end
        end
    end

    fft_frame_ram #(
        .WIDTH     (2 * DATA_WIDTH),
        .ADDR_BITS (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({in_im, in_re}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (s_axi_data)
    );

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: scenario table plus hand-written reset/ignore sequences.
module tb_fft_frame_feeder;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int N  = 1 << (AW + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fft_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_ready;
    logic [2*DW-1:0] s_axi_data;
    logic          s_axi_valid;
    logic          s_axi_last;
    logic          s_axi_ready = 1'b0;
    logic          busy;
    logic          start_drop;

    int checks = 0;
    int failures = 0;
    logic [2*DW-1:0] exp_q[$];

    typedef struct {
        string name;
        int    ready_pct;
        int    start_a;   // fill index at which to pulse fft_start, -1 for none
        int    start_b;
        bit    exp_drop;
    } scen_t;

    always #5 clk = ~clk;

    fft_frame_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fft_start   (fft_start),
        .in_valid    (in_valid),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_ready    (in_ready),
        .s_axi_data  (s_axi_data),
        .s_axi_valid (s_axi_valid),
        .s_axi_last  (s_axi_last),
        .s_axi_ready (s_axi_ready),
        .busy        (busy),
        .start_drop  (start_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write one ramp frame (re = base+i, im = -re), optionally pulsing fft_start mid-fill.
    task automatic fill(input int base, input int start_a, input int start_b);
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] re;
            logic [DW-1:0] im;
            re = DW'(base + i);
            im = -re;
            check("fill_in_ready", in_ready, 1);
            check("fill_busy", busy, 0);
            in_valid  = 1'b1;
            in_re     = re;
            in_im     = im;
            fft_start = (i == start_a) || (i == start_b);
            exp_q.push_back({im, re});
            step();
        end
        in_valid  = 1'b0;
        fft_start = 1'b0;
    endtask

    // Buffer full, no start queued: must idle and ignore front-end data until pulsed.
    task automatic kick_manual();
        in_valid = 1'b1;
        in_re    = 16'hDEAD;
        in_im    = 16'hDEAD;
        repeat (3) begin
            check("full_idle_busy", busy, 0);
            check("full_in_ready", in_ready, 0);
            check("full_idle_valid", s_axi_valid, 0);
            step();
        end
        in_valid  = 1'b0;
        fft_start = 1'b1;
        step();
        fft_start = 1'b0;
        check("kick_prime_busy", busy, 1);
        check("kick_prime_valid", s_axi_valid, 0);
        step();
        check("kick_valid_k2", s_axi_valid, 1);
    endtask

    // Start already queued: FULL, PRIME, then valid on the third cycle after the last write.
    task automatic kick_pending();
        check("pend_full_busy", busy, 0);
        check("pend_full_valid", s_axi_valid, 0);
        step();
        check("pend_prime_busy", busy, 1);
        check("pend_prime_valid", s_axi_valid, 0);
        step();
        check("pend_valid_k3", s_axi_valid, 1);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready_low", in_ready, 0);
        step();
        rst_n       = 1'b1;
        s_axi_ready = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", s_axi_valid, 0);
        check("rst_last", s_axi_last, 0);
        check("rst_busy", busy, 0);
        check("rst_data", s_axi_data, 0);
        check("rst_drop", start_drop, 0);
        check("rst_in_ready_high", in_ready, 1);
    endtask

    // Drain one frame with random ready; abort_at >= 0 applies a reset at that beat.
    task automatic send(input int pct, input int abort_at, input bit dead);
        int              beat = 0;
        int              cyc = 0;
        bit              stalled = 1'b0;
        logic [2*DW-1:0] hold_d = '0;
        logic            hold_l = 1'b0;
        logic [2*DW-1:0] exp;
        if (dead) begin
            in_valid = 1'b1;
            in_re    = 16'hDEAD;
            in_im    = 16'hDEAD;
        end
        while (beat < N) begin
            if (cyc > 20 * N) begin
                check("send_timeout_beats", beat, N);
                s_axi_ready = 1'b0;
                in_valid    = 1'b0;
                return;
            end
            if (beat == abort_at) begin
                in_valid = 1'b0;
                reset_pulse();
                return;
            end
            check("valid_held", s_axi_valid, 1);
            check("busy_send", busy, 1);
            if (stalled) begin
                check("stall_data", s_axi_data, hold_d);
                check("stall_last", s_axi_last, hold_l);
            end
            s_axi_ready = ($urandom_range(99) < pct);
            if (s_axi_ready) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check($sformatf("beat%0d_data", beat), s_axi_data, exp);
                check($sformatf("beat%0d_last", beat), s_axi_last, beat == N - 1);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold_d  = s_axi_data;
                hold_l  = s_axi_last;
            end
            cyc++;
            step();
        end
        s_axi_ready = 1'b0;
        in_valid    = 1'b0;
        check("end_valid", s_axi_valid, 0);
        check("end_last", s_axi_last, 0);
        check("end_busy", busy, 0);
        check("end_in_ready", in_ready, 1);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        scen_t tbl[5];
        tbl[0] = '{"ramp_full_rate",   100, -1,  -1, 1'b0};
        tbl[1] = '{"ramp_random_rdy",   50, -1,  -1, 1'b0};
        tbl[2] = '{"start_mid_fill",   100, 500, -1, 1'b0};
        tbl[3] = '{"double_start",      60, 100, 600, 1'b1};
        tbl[4] = '{"drop_sticky",      100, -1,  -1, 1'b1};

        rst_n = 1'b0;
        step();
        step();
        check("init_in_ready_low", in_ready, 0);
        check("init_valid", s_axi_valid, 0);
        check("init_last", s_axi_last, 0);
        check("init_busy", busy, 0);
        check("init_data", s_axi_data, 0);
        check("init_drop", start_drop, 0);
        rst_n = 1'b1;
        #1;
        check("init_in_ready_high", in_ready, 1);

        for (int t = 0; t < 5; t++) begin
            fill(t * 37, tbl[t].start_a, tbl[t].start_b);
            if (tbl[t].start_a < 0 && tbl[t].start_b < 0) begin
                kick_manual();
            end else begin
                kick_pending();
            end
            send(tbl[t].ready_pct, -1, 1'b0);
            check($sformatf("%s_start_drop", tbl[t].name), start_drop, tbl[t].exp_drop);
        end

        // Reset mid-frame, then a fresh frame must come out whole from sample 0.
        fill(500, -1, -1);
        kick_manual();
        send(100, 300, 1'b0);
        fill(600, -1, -1);
        kick_manual();
        send(75, -1, 1'b0);
        check("post_reset_drop", start_drop, 0);

        // Front-end data during SEND must not leak into the following frame.
        fill(900, -1, -1);
        kick_manual();
        send(100, -1, 1'b1);
        fill(1200, -1, -1);
        kick_manual();
        send(80, -1, 1'b0);
        check("final_drop", start_drop, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Source-side counterpart of the FFT start-pulse generator: buffers one frame of complex samples and streams it into the FFT input AXI-stream (s_axi_*), one frame per fft_start pulse.
- Sits between the sample front end (ADC/DDC) and the Burst FFT/IFFT core input port.
- fft_start comes from the start generator, which pulses after reset and at the end of each FFT output frame.

Parameters:
DATA_WIDTH, 16, width of each real/imag component (8 and up)
ADDR_WIDTH, 9, frame length N = 2^(ADDR_WIDTH+1) (default 1024)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
fft_start  input  1  single-cycle request to transmit one frame
in_valid  input  1  sample strobe from front end
in_re  input  DATA_WIDTH  sample real part
in_im  input  DATA_WIDTH  sample imaginary part
in_ready  output  1  buffer accepting samples
s_axi_data  output  2*DATA_WIDTH  {im, re} to FFT
s_axi_valid  output  1  AXI-stream valid
s_axi_last  output  1  high on final (N-th) sample of frame
s_axi_ready  input  1  FFT ready
busy  output  1  state is PRIME or SEND
start_drop  output  1  sticky: fft_start arrived while a start was already pending

Behaviour:
- Reset (rst_n low at clk edge): state FILL, wr_addr=0, rd_addr=0, start_pending=0, start_drop=0. s_axi_valid, s_axi_last, s_axi_data, busy all 0. in_ready is forced 0 while rst_n is low. Buffered frame is discarded.
- States:
  - FILL: in_ready=1. Each in_valid writes {im,re} at wr_addr, then wr_addr+1. The write at wr_addr=N-1 goes to FULL and wraps wr_addr to 0.
  - FULL: in_ready=0; wait for start_pending or fft_start.
  - PRIME: issue RAM read of address 0; in_ready=0.
  - SEND: stream out; in_ready=0.
- start_pending:
  - Set by fft_start in any state except FULL. In FULL, fft_start moves directly to PRIME.
  - Cleared on the FULL->PRIME transition.
  - fft_start while start_pending=1 sets start_drop; no extra frame is produced.
- Latency:
  - fft_start high in cycle k while in FULL: PRIME in k+1, s_axi_valid=1 from k+2 carrying sample 0.
  - If start is pending when the last sample is written in cycle k: FULL in k+1, PRIME in k+2, s_axi_valid in k+3.
- AXI-stream rules:
  - Once s_axi_valid is asserted, s_axi_data and s_axi_last hold stable until s_axi_valid & s_axi_ready.
  - s_axi_valid never drops mid-frame.
  - RAM read enable = PRIME | (SEND & valid & ready & !last_sent); rd_addr increments on each read. With ready held high, throughput is 1 sample/clk.
- End of frame:
  - s_axi_last=1 exactly on sample N-1.
  - Handshake of that sample: s_axi_valid=0 and s_axi_last=0 next cycle; state FILL, in_ready=1 next cycle.
  - Samples are emitted in write order.
- Front-end data: in_valid while in_ready=0 is ignored; no write occurs and no flag is raised.
- start_drop clears only on reset.
- Reset mid-SEND: valid, last and busy go 0 at the reset edge. The partial frame is abandoned and the next frame refills from address 0.
- Counters: wr_addr and rd_addr are ADDR_WIDTH+1 bits and wrap naturally at N.

Decomposition:
- Shared package: state encoding (FILL, FULL, PRIME, SEND) and localparam FFT_LEN = 1 << (ADDR_WIDTH+1).
- One natural sub-module: fft_frame_ram, a simple dual-port synchronous RAM with N x 2*DATA_WIDTH storage and a read enable. Its registered output holds when read enable is low and drives s_axi_data directly.

Test Plan:
- Fill ramp (N=1024, re=i, im=-i), pulse fft_start in cycle k -> valid from k+2; 1024 beats re=0..1023 with s_axi_ready=1; last only on beat 1023; in_ready=1 the cycle after.
- Random s_axi_ready (50%) on the same ramp -> data and last stable while stalled; no beat duplicated or lost; valid never drops before the last handshake.
- fft_start pulsed at sample 500 of fill -> busy=0 until fill completes; s_axi_valid rises 3 cycles after write of sample 1023; start_drop stays 0.
- Two fft_start pulses during fill -> exactly one frame sent; start_drop=1 and stays 1 through the next frame.
- rst_n low for 1 cycle at beat 300 of SEND -> valid=0 and busy=0 after that edge; in_ready=1 once rst_n is high. A fresh 1024-sample frame sends correctly from sample 0.
- in_valid held high during SEND with distinct data (0xDEAD) -> 0xDEAD never appears in the next frame output.
